// File: rtl/toe_pkg.sv
// Shared types and register map for the TCP offload connection table.
package toe_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned TUPLE_W = 192;

   typedef struct packed {
      logic [47:0] srcmac;
      logic [47:0] dstmac;
      logic [31:0] srcip;
      logic [31:0] dstip;
      logic [15:0] srcport;
      logic [15:0] dstport;
   } tuple_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_KILL   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_FULL   = 2'd1,
      ERR_DUP    = 2'd2,
      ERR_BADCMD = 2'd3
   } err_e;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_TUPLE0 = 3'd2;

endpackage

// File: rtl/toe_conn_table_if.sv
// Register-slave bus between a host and the connection table.
interface toe_conn_table_if;
   logic                         chipselect;
   logic                         write;
   logic                         read;
   logic [toe_pkg::ADDR_W-1:0]   address;
   logic [toe_pkg::DATA_W-1:0]   writedata;
   logic [toe_pkg::DATA_W-1:0]   readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/toe_conn_mem.sv
// Connection slot storage: valid bit plus tuple per slot, one async read port,
// one synchronous write port and one synchronous clear port.
module toe_conn_mem
   import toe_pkg::*;
#(
   parameter int unsigned N_CONN = 16,
   parameter int unsigned ID_W   = $clog2(N_CONN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ID_W-1:0] rd_idx,
   output logic            rd_valid_c,
   output tuple_t          rd_tuple_c,
   input  logic            wr_en,
   input  logic [ID_W-1:0] wr_idx,
   input  tuple_t          wr_tuple,
   input  logic            clr_en,
   input  logic [ID_W-1:0] clr_idx
);

   logic [N_CONN-1:0] valid_q, valid_d;
   tuple_t            tuple_mem [N_CONN];

   // Indices past N_CONN (non power-of-two tables) read as an empty slot.
   assign rd_valid_c = (32'(rd_idx) < N_CONN) && valid_q[rd_idx];
   assign rd_tuple_c = tuple_mem[rd_idx];

   always_comb begin
      valid_d = valid_q;
      if (wr_en)  valid_d[wr_idx]  = 1'b1;
      if (clr_en) valid_d[clr_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Tuple contents are qualified by valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en) tuple_mem[wr_idx] <= wr_tuple;
   end

endmodule

// File: rtl/toe_conn_table.sv
// Connection table: host stages a tuple, NEW scans for a duplicate / lowest free
// slot and commits it, KILL releases a slot; results reported via STATUS.
module toe_conn_table
   import toe_pkg::*;
#(
   parameter int unsigned N_CONN = 16,
   parameter int unsigned ID_W   = $clog2(N_CONN)
) (
   input logic              clk,
   input logic              reset,
   toe_conn_table_if.slave  bus
);

   localparam int unsigned CNT_W = ID_W + 1;

   state_e             state_q, state_d;
   tuple_t             stage_q, stage_d;
   logic [ID_W-1:0]    scan_idx_q, scan_idx_d;
   logic [ID_W-1:0]    free_idx_q, free_idx_d;
   logic               found_free_q, found_free_d;
   logic               dup_q, dup_d;
   logic [ID_W-1:0]    kill_id_q, kill_id_d;
   logic [ID_W-1:0]    new_id_q, new_id_d;
   logic [1:0]         done_q, done_d;
   err_e               err_q, err_d;
   logic               overrun_q, overrun_d;
   logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
   logic [DATA_W-1:0]  readdata_q, readdata_d;

   logic               wr_acc_c, busy_c, reg_wr_c;
   logic [ID_W-1:0]    rd_idx_c;
   logic               mem_rd_valid_c, mem_wr_en_c, mem_clr_en_c;
   tuple_t             mem_rd_tuple_c;
   logic [TUPLE_W-1:0] stage_vec_c;
   logic [ADDR_W-1:0]  widx_c;
   logic [DATA_W-1:0]  status_c;

   toe_conn_mem #(.N_CONN(N_CONN), .ID_W(ID_W)) u_mem (
      .clk        (clk),
      .rst_n      (reset),
      .rd_idx     (rd_idx_c),
      .rd_valid_c (mem_rd_valid_c),
      .rd_tuple_c (mem_rd_tuple_c),
      .wr_en      (mem_wr_en_c),
      .wr_idx     (free_idx_q),
      .wr_tuple   (stage_q),
      .clr_en     (mem_clr_en_c),
      .clr_idx    (kill_id_q)
   );

   assign busy_c   = (state_q != ST_IDLE);
   assign wr_acc_c = bus.chipselect && bus.write;
   assign reg_wr_c = wr_acc_c && (bus.address == ADDR_CTRL || bus.address >= ADDR_TUPLE0);
   assign widx_c   = bus.address - ADDR_TUPLE0;
   assign status_c = {8'(free_cnt_q), 2'b00, overrun_q, busy_c, err_q, done_q, 16'(new_id_q)};
   assign rd_idx_c = (state_q == ST_KILL) ? kill_id_q : scan_idx_q;
   assign bus.readdata = readdata_q;

   always_comb begin
      state_d      = state_q;
      stage_d      = stage_q;
      scan_idx_d   = scan_idx_q;
      free_idx_d   = free_idx_q;
      found_free_d = found_free_q;
      dup_d        = dup_q;
      kill_id_d    = kill_id_q;
      new_id_d     = new_id_q;
      done_d       = done_q;
      err_d        = err_q;
      overrun_d    = overrun_q;
      free_cnt_d   = free_cnt_q;
      readdata_d   = readdata_q;
      mem_wr_en_c  = 1'b0;
      mem_clr_en_c = 1'b0;
      stage_vec_c  = stage_q;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_acc_c && bus.address == ADDR_CTRL) begin
               if (bus.writedata[0] && !bus.writedata[1]) begin
                  state_d      = ST_SCAN;
                  scan_idx_d   = '0;
                  found_free_d = 1'b0;
                  dup_d        = 1'b0;
                  done_d       = 2'b00;
                  err_d        = ERR_NONE;
                  overrun_d    = 1'b0;
               end else if (bus.writedata[1] && !bus.writedata[0]) begin
                  state_d   = ST_KILL;
                  kill_id_d = bus.writedata[8 +: ID_W];
                  done_d    = 2'b00;
                  err_d     = ERR_NONE;
                  overrun_d = 1'b0;
               end else begin
                  err_d = ERR_BADCMD;
               end
            end else if (wr_acc_c && bus.address >= ADDR_TUPLE0) begin
               stage_vec_c[{widx_c, 5'd0} +: DATA_W] = bus.writedata;
               stage_d = tuple_t'(stage_vec_c);
            end
         end
         ST_SCAN: begin
            if (mem_rd_valid_c && mem_rd_tuple_c == stage_q) dup_d = 1'b1;
            if (!mem_rd_valid_c && !found_free_q) begin
               found_free_d = 1'b1;
               free_idx_d   = scan_idx_q;
            end
            if (scan_idx_q == ID_W'(N_CONN - 1)) state_d = ST_COMMIT;
            else                                 scan_idx_d = scan_idx_q + ID_W'(1);
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            if (dup_q) begin
               err_d = ERR_DUP;
            end else if (!found_free_q) begin
               err_d = ERR_FULL;
            end else begin
               mem_wr_en_c = 1'b1;
               new_id_d    = free_idx_q;
               done_d      = 2'b01;
               if (free_cnt_q != '0) free_cnt_d = free_cnt_q - CNT_W'(1);
            end
         end
         ST_KILL: begin
            state_d = ST_IDLE;
            if (32'(kill_id_q) < N_CONN && mem_rd_valid_c) begin
               mem_clr_en_c = 1'b1;
               done_d       = 2'b10;
               if (free_cnt_q < CNT_W'(N_CONN)) free_cnt_d = free_cnt_q + CNT_W'(1);
            end else begin
               err_d = ERR_BADCMD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (busy_c && reg_wr_c) overrun_d = 1'b1;

      // Reads sample the pre-write register values.
      if (bus.chipselect && bus.read) begin
         if (bus.address == ADDR_STATUS)      readdata_d = status_c;
         else if (bus.address >= ADDR_TUPLE0) readdata_d = stage_vec_c[{widx_c, 5'd0} +: DATA_W];
         else                                 readdata_d = '0;
         if (bus.address >= ADDR_TUPLE0) begin
            stage_vec_c = stage_q;
            readdata_d  = stage_vec_c[{widx_c, 5'd0} +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         stage_q      <= '0;
         scan_idx_q   <= '0;
         free_idx_q   <= '0;
         found_free_q <= 1'b0;
         dup_q        <= 1'b0;
         kill_id_q    <= '0;
         new_id_q     <= '0;
         done_q       <= 2'b00;
         err_q        <= ERR_NONE;
         overrun_q    <= 1'b0;
         free_cnt_q   <= CNT_W'(N_CONN);
         readdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         stage_q      <= stage_d;
         scan_idx_q   <= scan_idx_d;
         free_idx_q   <= free_idx_d;
         found_free_q <= found_free_d;
         dup_q        <= dup_d;
         kill_id_q    <= kill_id_d;
         new_id_q     <= new_id_d;
         done_q       <= done_d;
         err_q        <= err_d;
         overrun_q    <= overrun_d;
         free_cnt_q   <= free_cnt_d;
         readdata_q   <= readdata_d;
      end
   end

endmodule

// File: tb/tb_toe_conn_table.sv
// Directed plus randomized bench for toe_conn_table against a slot-array model.
module tb_toe_conn_table;

   localparam int unsigned N = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   toe_conn_table_if bus ();
   toe_conn_table #(.N_CONN(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   bit           ref_valid [N];
   logic [191:0] ref_tuple [N];
   logic [191:0] staged;
   int           m_new_id;
   logic [1:0]   m_done, m_err;
   bit           m_ovr;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin ref_valid[i] = 0; ref_tuple[i] = '0; end
      staged = '0; m_new_id = 0; m_done = 0; m_err = 0; m_ovr = 0;
   endfunction

   function automatic logic [31:0] exp_status(bit busy);
      int f;
      f = 0;
      for (int i = 0; i < N; i++) if (!ref_valid[i]) f++;
      return {8'(f), 2'b00, m_ovr, busy, m_err, m_done, 16'(m_new_id)};
   endfunction

   function automatic void model_new();
      bit dup;
      int fr;
      dup = 0; fr = -1;
      for (int i = 0; i < N; i++) begin
         if (ref_valid[i] && ref_tuple[i] == staged) dup = 1;
         if (!ref_valid[i] && fr < 0) fr = i;
      end
      m_done = 0; m_err = 0; m_ovr = 0;
      if (dup)         m_err = 2;
      else if (fr < 0) m_err = 1;
      else begin
         ref_valid[fr] = 1; ref_tuple[fr] = staged; m_new_id = fr; m_done = 2'b01;
      end
   endfunction

   function automatic void model_kill(int id);
      m_done = 0; m_err = 0; m_ovr = 0;
      if (id < N && ref_valid[id]) begin ref_valid[id] = 0; m_done = 2'b10; end
      else m_err = 3;
   endfunction

   function automatic logic [191:0] rand_tuple();
      logic [191:0] t;
      for (int k = 0; k < 6; k++) t[32*k +: 32] = $urandom;
      return t;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = d;
      @(posedge clk); #1;
      bus.chipselect = 0; bus.write = 0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.chipselect = 1; bus.read = 1; bus.address = a;
      @(posedge clk); #1;
      d = bus.readdata;
      bus.chipselect = 0; bus.read = 0;
   endtask

   task automatic rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
      bus.chipselect = 1; bus.read = 1; bus.write = 1; bus.address = a; bus.writedata = wd;
      @(posedge clk); #1;
      d = bus.readdata;
      bus.chipselect = 0; bus.read = 0; bus.write = 0;
   endtask

   task automatic stage(input logic [191:0] t);
      for (int k = 0; k < 6; k++) wr(3'(2 + k), t[32*k +: 32]);
      staged = t;
   endtask

   task automatic wait_idle(output logic [31:0] s);
      s = '1;
      for (int i = 0; i < 60 && s[20]; i++) rd(3'd1, s);
      check("idle_timeout", {31'b0, s[20]}, 32'd0);
   endtask

   task automatic do_new(input string tag, input logic [191:0] t);
      logic [31:0] s;
      stage(t);
      wr(3'd0, 32'h1);
      model_new();
      wait_idle(s);
      check(tag, s, exp_status(0));
   endtask

   task automatic do_kill(input string tag, input int id);
      logic [31:0] s;
      wr(3'd0, (32'(id) << 8) | 32'h2);
      model_kill(id);
      wait_idle(s);
      check(tag, s, exp_status(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [31:0]  s;
      logic [191:0] ta, t;
      logic [191:0] pool [4];

      bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0; bus.writedata = '0;
      reset = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_readdata", bus.readdata, 32'h0);
      reset = 1;
      @(posedge clk); #1;
      rd(3'd1, s);
      check("reset_status", s, 32'h1000_0000);

      // First NEW: still busy in the commit cycle, result readable 18 cycles after CTRL.
      ta = rand_tuple();
      ta[31:0] = 32'hDEAD_0000;
      stage(ta);
      rd(3'd2, s);
      check("tuple0_readback", s, ta[31:0]);
      rd(3'd7, s);
      check("tuple5_readback", s, ta[191:160]);
      wr(3'd0, 32'h1);
      model_new();
      repeat (16) @(posedge clk);
      #1;
      rd(3'd1, s);
      check("new_busy_commit_cycle", s, 32'h1010_0000);
      rd(3'd1, s);
      check("new_latency_result", s, exp_status(0));
      check("new_first_const", s, 32'h0F01_0000);

      do_new("new_dup", ta);
      check("dup_const", exp_status(0), 32'h0F08_0000);

      for (int i = 1; i < 16; i++) begin
         t = rand_tuple();
         t[31:0] = 32'(i);
         do_new($sformatf("fill_%0d", i), t);
      end
      t = rand_tuple(); t[31:0] = 32'd100;
      do_new("new_full", t);

      // Kill has 2-cycle latency: busy after 1, done after 2.
      wr(3'd0, 32'h0000_0502);
      model_kill(5);
      rd(3'd1, s);
      check("kill_busy", {31'b0, s[20]}, 32'd1);
      rd(3'd1, s);
      check("kill5_done", s, exp_status(0));
      t = rand_tuple(); t[31:0] = 32'd200;
      do_new("reuse_slot5", t);

      do_kill("kill5_again", 5);
      do_kill("kill5_free", 5);
      wr(3'd0, 32'h3); m_err = 3;
      rd(3'd1, s);
      check("ctrl_both", s, exp_status(0));
      wr(3'd0, 32'h0); m_err = 3;
      rd(3'd1, s);
      check("ctrl_none", s, exp_status(0));

      // Writes during a scan are dropped and flag overrun.
      t = rand_tuple(); t[31:0] = 32'd300;
      stage(t);
      wr(3'd0, 32'h1);
      model_new();
      wr(3'd0, 32'h0000_0302);
      wr(3'd2, 32'h1234_5678);
      m_ovr = 1;
      wait_idle(s);
      check("overrun_result", s, exp_status(0));
      rd(3'd2, s);
      check("overrun_stage_kept", s, staged[31:0]);

      rw(3'd2, 32'hCAFE_F00D, s);
      check("rw_pre_value", s, staged[31:0]);
      staged[31:0] = 32'hCAFE_F00D;
      rd(3'd2, s);
      check("rw_post_value", s, 32'hCAFE_F00D);

      for (int j = 0; j < 4; j++) begin
         pool[j] = rand_tuple();
         pool[j][31:0] = 32'h1000 + 32'(j);
      end
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 1) do_new($sformatf("rand_new_%0d", n), pool[$urandom_range(0, 3)]);
         else do_kill($sformatf("rand_kill_%0d", n), int'($urandom_range(0, N - 1)));
      end

      // Reset during scan cycle 7 aborts the NEW.
      t = rand_tuple(); t[31:0] = 32'd400;
      stage(t);
      wr(3'd0, 32'h1);
      repeat (7) @(posedge clk);
      #2;
      reset = 0;
      #1;
      model_reset();
      check("midscan_reset_readdata", bus.readdata, 32'h0);
      @(posedge clk); #1;
      reset = 1;
      rd(3'd1, s);
      check("midscan_reset_status", s, 32'h1000_0000);
      rd(3'd2, s);
      check("midscan_reset_stage", s, 32'h0);
      do_new("after_reset_new", t);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
